pop_referee: RTL and testbench

- Drain-side referee for the transaction-layer FIFO bank.
- Reads words out of NUM_FIFOS upstream FIFOs by pulsing their pop inputs in round-robin order.
- Pushes each word into a single downstream FIFO and respects that FIFO's almost_full back-pressure.
- Pairs with the push-side referees: they write the FIFOs, this block reads them.

---
 rtl/fifo_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 22 ++
 rtl/pop_referee.sv | 54 +++++
 tb/tb_pop_referee.sv | 130 +++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state encodings and size defaults for the FIFO bank referees
package fifo_pkg;
  localparam int DEF_LINE_SIZE = 12;
  localparam int DEF_NUM_FIFOS = 4;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_STALL = 2'd2} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after rr_ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] rr_ptr,
  output logic          grant_valid,
  output logic [SW-1:0] g
);
  logic [SW-1:0] w_idx;
  // Scan from the far end back toward rr_ptr so the closest requester wins last
  always_comb begin
    grant_valid = |req;
    g = '0;
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = SW'((int'(rr_ptr) + i) % N);
      if (req[w_idx]) g = w_idx;
    end
  end
endmodule

// File: rtl/pop_referee.sv
// pop_referee: round-robin drain of NUM_FIFOS upstream FIFOs into one downstream FIFO
module pop_referee import fifo_pkg::*; #(
  parameter int LINE_SIZE = DEF_LINE_SIZE,
  parameter int NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int SEL_SIZE  = $clog2(NUM_FIFOS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_FIFOS-1:0]           fifo_empty,
  input  logic [NUM_FIFOS*LINE_SIZE-1:0] fifo_data,
  output logic [NUM_FIFOS-1:0]           pop,
  input  logic                           dst_almost_full,
  output logic                           push,
  output logic [LINE_SIZE-1:0]           data_out,
  output logic [SEL_SIZE-1:0]            src_sel,
  output state_t                         state
);
  logic [NUM_FIFOS-1:0] w_req;
  logic                 w_any, w_gnt, r_v1;
  logic [SEL_SIZE-1:0]  w_g, r_ptr, r_s1;
  state_t               w_nxt;
  assign w_req = ~fifo_empty;
  assign w_gnt = reset && !dst_almost_full && w_any;
  assign pop   = w_gnt ? {{(NUM_FIFOS-1){1'b0}}, 1'b1} << w_g : '0;
  rr_arbiter #(.N(NUM_FIFOS), .SW(SEL_SIZE)) u_arb (
    .req(w_req), .rr_ptr(r_ptr), .grant_valid(w_any), .g(w_g)
  );
  always_comb begin
    w_nxt = dst_almost_full ? ((state == ST_IDLE && !w_any) ? ST_IDLE : ST_STALL)
                            : (w_any ? ST_ACTIVE : ST_IDLE);
  end
  // Upstream data_out is registered, so the popped word is captured one cycle after the pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr    <= '0;
      r_v1     <= 1'b0;
      r_s1     <= '0;
      push     <= 1'b0;
      data_out <= '0;
      src_sel  <= '0;
      state    <= ST_IDLE;
    end else begin
      if (w_gnt) r_ptr <= (w_g == SEL_SIZE'(NUM_FIFOS - 1)) ? '0 : w_g + 1'b1;
      r_v1  <= w_gnt;
      r_s1  <= w_g;
      push  <= r_v1;
      state <= w_nxt;
      if (r_v1) begin
        data_out <= fifo_data[r_s1*LINE_SIZE +: LINE_SIZE];
        src_sel  <= r_s1;
      end
    end
  end
endmodule

// File: tb/tb_pop_referee.sv
// tb_pop_referee: directed checks of pop_referee against hand-computed vectors
module tb_pop_referee;
  import fifo_pkg::*;
  logic        clk, reset, af, push;
  logic [3:0]  fe, pop;
  logic [47:0] fd;
  logic [11:0] dout, dr [4];
  logic [1:0]  sel;
  state_t      st;
  logic [11:0] q [4][$];
  int          n_run, n_fail;
  logic [3:0]  ep  [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h4, 4'h0, 4'h0, 4'h0};
  logic        epu [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
  logic [11:0] ed  [9] = '{12'h0, 12'h0, 12'h100, 12'h110, 12'h120, 12'h130, 12'h101, 12'h121, 12'h121};
  logic [1:0]  es  [9] = '{0, 0, 0, 1, 2, 3, 0, 2, 2};
  assign fd = {dr[3], dr[2], dr[1], dr[0]};
  pop_referee dut (
    .clk(clk), .reset(reset), .fifo_empty(fe), .fifo_data(fd), .pop(pop),
    .dst_almost_full(af), .push(push), .data_out(dout), .src_sel(sel), .state(st)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic load(int i, logic [11:0] w);
    q[i].push_back(w);
    fe[i] = 1'b0;
  endtask
  // Upstream FIFO model: a pop seen at the edge moves the head word onto that FIFO's data_out
  task automatic tick();
    logic [3:0] p;
    p = pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (p[i] && q[i].size() > 0) dr[i] = q[i].pop_front();
      fe[i] = (q[i].size() == 0);
    end
    @(negedge clk);
  endtask
  initial begin
    n_run = 0; n_fail = 0;
    reset = 1'b0; af = 1'b0; fe = 4'hF;
    for (int i = 0; i < 4; i++) dr[i] = '0;
    @(negedge clk); #1;
    chk("rst_pop", 32'(pop), 0); chk("rst_push", 32'(push), 0);
    chk("rst_state", 32'(st), 0); chk("rst_data", 32'(dout), 0);
    tick(); reset = 1'b1; #1;
    for (int c = 0; c < 3; c++) begin
      chk("idle_pop", 32'(pop), 0); chk("idle_push", 32'(push), 0);
      chk("idle_state", 32'(st), 0); chk("idle_data", 32'(dout), 0);
      tick();
    end
    load(2, 12'h0A1); load(2, 12'h0A2); load(2, 12'h0A3); #1;
    chk("single_pop_t0", 32'(pop), 4'h4); tick();
    chk("single_pop_t1", 32'(pop), 4'h4); chk("single_state_t1", 32'(st), 1);
    chk("single_push_t1", 32'(push), 0); tick();
    chk("single_pop_t2", 32'(pop), 4'h4); chk("single_push_t2", 32'(push), 1);
    chk("single_data_t2", 32'(dout), 12'h0A1); chk("single_sel_t2", 32'(sel), 2); tick();
    chk("single_pop_t3", 32'(pop), 0); chk("single_data_t3", 32'(dout), 12'h0A2);
    chk("single_push_t3", 32'(push), 1); tick();
    chk("single_data_t4", 32'(dout), 12'h0A3); chk("single_push_t4", 32'(push), 1);
    chk("single_state_t4", 32'(st), 0); tick();
    chk("single_push_t5", 32'(push), 0); chk("single_hold_t5", 32'(dout), 12'h0A3);
    reset = 1'b0; #1;
    chk("rst2_data", 32'(dout), 0);
    tick(); reset = 1'b1;
    load(0, 12'h100); load(0, 12'h101); load(1, 12'h110);
    load(2, 12'h120); load(2, 12'h121); load(3, 12'h130); #1;
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("rr_pop_c%0d", c), 32'(pop), 32'(ep[c]));
      chk($sformatf("rr_push_c%0d", c), 32'(push), 32'(epu[c]));
      chk($sformatf("rr_data_c%0d", c), 32'(dout), 32'(ed[c]));
      chk($sformatf("rr_sel_c%0d", c), 32'(sel), 32'(es[c]));
      tick();
    end
    for (int k = 0; k < 8; k++) load(1, 12'(12'h200 + k)); #1;
    chk("bp_pop_a", 32'(pop), 4'h2); tick();
    chk("bp_pop_b", 32'(pop), 4'h2); tick();
    af = 1'b1; #1;
    chk("bp_pop_c", 32'(pop), 0); chk("bp_push_c", 32'(push), 1);
    chk("bp_data_c", 32'(dout), 12'h200); chk("bp_state_c", 32'(st), 1); tick();
    chk("bp_push_d", 32'(push), 1); chk("bp_data_d", 32'(dout), 12'h201);
    chk("bp_state_d", 32'(st), 2); chk("bp_pop_d", 32'(pop), 0); tick();
    chk("bp_push_e", 32'(push), 0); chk("bp_state_e", 32'(st), 2); tick();
    chk("bp_push_e2", 32'(push), 0); chk("bp_pop_e2", 32'(pop), 0);
    af = 1'b0; #1;
    chk("bp_pop_f", 32'(pop), 4'h2); chk("bp_state_f", 32'(st), 2); tick();
    chk("bp_state_g", 32'(st), 1); chk("bp_pop_g", 32'(pop), 4'h2); tick();
    chk("bp_push_h", 32'(push), 1); chk("bp_data_h", 32'(dout), 12'h202);
    for (int k = 0; k < 8; k++) tick();
    chk("bp_drain_push", 32'(push), 0); chk("bp_drain_state", 32'(st), 0);
    chk("bp_drain_data", 32'(dout), 12'h207);
    af = 1'b1; load(3, 12'h300); load(3, 12'h301); #1;
    chk("sim_pop_0", 32'(pop), 0); chk("sim_state_0", 32'(st), 0); tick();
    chk("sim_state_1", 32'(st), 2); chk("sim_pop_1", 32'(pop), 0);
    af = 1'b0; #1;
    chk("sim_pop_fall", 32'(pop), 4'h8); tick();
    chk("sim_pop_2", 32'(pop), 4'h8); tick();
    chk("sim_push_3", 32'(push), 1); chk("sim_data_3", 32'(dout), 12'h300);
    chk("sim_sel_3", 32'(sel), 3); tick();
    chk("sim_data_4", 32'(dout), 12'h301); tick();
    load(0, 12'h310); load(1, 12'h311); #1;
    chk("wrap_pop", 32'(pop), 4'h1);
    for (int k = 0; k < 4; k++) tick();
    load(0, 12'h400); #1;
    chk("mid_pop", 32'(pop), 4'h1); tick();
    reset = 1'b0; #1;
    chk("mid_rst_pop", 32'(pop), 0); chk("mid_rst_push", 32'(push), 0);
    chk("mid_rst_state", 32'(st), 0); tick();
    chk("mid_rst_push2", 32'(push), 0);
    reset = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid_nopush_%0d", k), 32'(push), 0);
      tick();
    end
    load(0, 12'h500); load(2, 12'h520); #1;
    chk("mid_ptr0_pop", 32'(pop), 4'h1); tick(); tick();
    chk("mid_new_push", 32'(push), 1); chk("mid_new_data", 32'(dout), 12'h500);
    chk("mid_new_sel", 32'(sel), 0); tick();
    chk("mid_new_data2", 32'(dout), 12'h520); tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
